// File: rtl/addsub_pkg.sv
// addsub_pkg: opcode constants and result-flag struct shared by the pipelined add/sub datapath
package addsub_pkg;
  localparam logic ADDSUB_OP_ADD = 1'b0;
  localparam logic ADDSUB_OP_SUB = 1'b1;
  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } addsub_flags_t;
endpackage

// File: rtl/addsub_segment.sv
// addsub_segment: combinational carry-chain slice, (a, b, cin) -> (sum, cout)
module addsub_segment #(
  parameter int SEG_WIDTH = 16
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: skewed pipelined add/sub, one carry slice per stage, valid/ready on both sides.
// Define ADDSUB_FLAGS_EN to add the out_carry/out_ovf/out_zero outputs.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
`ifdef ADDSUB_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
`endif
);
  localparam int STAGES = WIDTH / SEG_WIDTH;
  localparam int L      = STAGES - 1;
  if (WIDTH % SEG_WIDTH != 0 || STAGES < 1) begin : g_chk
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of SEG_WIDTH");
  end
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  // Stage k consumes the low slice of the pending operands; done result bits grow by one slice per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int PW = WIDTH - k * SEG_WIDTH;
    logic [PW-1:0]                pa, pb;
    logic                         pc, pv, co;
    logic [SEG_WIDTH-1:0]         s;
    logic [(k+1)*SEG_WIDTH-1:0]   r_d, r_q;
    logic                         v_q;
    if (k == 0) begin : g_in
      assign pa  = in_a;
      assign pb  = in_b ^ {WIDTH{in_sub == ADDSUB_OP_SUB}};
      assign pc  = in_sub == ADDSUB_OP_SUB;
      assign pv  = in_valid;
      assign r_d = s;
    end else begin : g_mid
      assign pa  = g_stage[k-1].g_pend.a_q;
      assign pb  = g_stage[k-1].g_pend.b_q;
      assign pc  = g_stage[k-1].g_pend.c_q;
      assign pv  = g_stage[k-1].v_q;
      assign r_d = {s, g_stage[k-1].r_q};
    end
    addsub_segment #(.SEG_WIDTH(SEG_WIDTH)) u_seg (
      .a   (pa[SEG_WIDTH-1:0]),
      .b   (pb[SEG_WIDTH-1:0]),
      .cin (pc),
      .sum (s),
      .cout(co)
    );
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        v_q <= 1'b0;
        r_q <= '0;
      end else if (adv) begin
        v_q <= pv;
        r_q <= r_d;
      end
    if (k < L) begin : g_pend
      logic [PW-SEG_WIDTH-1:0] a_q, b_q;
      logic                    c_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          a_q <= pa[PW-1:SEG_WIDTH];
          b_q <= pb[PW-1:SEG_WIDTH];
          c_q <= co;
        end
    end
  end
  assign out_valid  = g_stage[L].v_q;
  assign out_result = g_stage[L].r_q;
`ifdef ADDSUB_FLAGS_EN
  // Final slice holds the operand MSBs (b already inverted for sub), so flags are formed here.
  addsub_flags_t flags_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) flags_q <= '0;
    else if (adv)
      flags_q <= '{
        carry: g_stage[L].co,
        ovf:   (g_stage[L].pa[SEG_WIDTH-1] == g_stage[L].pb[SEG_WIDTH-1]) &&
               (g_stage[L].s[SEG_WIDTH-1] != g_stage[L].pa[SEG_WIDTH-1]),
        zero:  g_stage[L].r_d == '0
      };
  assign out_carry = flags_q.carry;
  assign out_ovf   = flags_q.ovf;
  assign out_zero  = flags_q.zero;
`endif
endmodule
